redundant_carry_norm: RTL and testbench
=======================================

Name: redundant_carry_norm

Overview:
- Downstream consumer of the constant-multiplier stage in the BN254 datapath.
- Accepts one redundant polynomial: NUM_LIMBS limbs, each LIMB_W+CARRY_W bits wide, where limb i carries weight 2^(i*LIMB_W).
- Ripples carries serially, one limb per cycle, and emits the equivalent non-redundant integer under a valid/ready handshake.
- Feeds the modular-reduction stage.

Parameters:
NUM_LIMBS, 4, number of redundant limbs (ADD_DIV in the datapath package).
LIMB_W, 64, weight step and non-redundant bits per limb.
CARRY_W, 3, extra headroom bits per input limb (covers the x6 worst case of the multiplier).

Ports:
clk  input  1  clock, all logic on rising edge.
rstn  input  1  reset; asynchronous, active-high (1 = reset), name kept from codebase.
in_valid  input  1  din holds a valid redundant value.
in_ready  output  1  block can accept din.
din  input  NUM_LIMBS*(LIMB_W+CARRY_W)  packed limbs, limb 0 in LSBs.
out_valid  output  1  dout valid.
out_ready  input  1  consumer accepts dout.
dout  output  NUM_LIMBS*LIMB_W+CARRY_W+1  non-redundant value, equal to sum of din[i]*2^(i*LIMB_W).
busy  output  1  FSM not in IDLE.

Behaviour:
- Reset (asynchronous assert, synchronous-safe release):
  - state=IDLE, in_ready=1, out_valid=0, busy=0.
  - dout=0, limb counter=0, carry register=0.
  - Internal limb buffer is cleared.
- FSM states: IDLE, PROP, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready at an edge: latch all din limbs, clear carry, set k=0, go to PROP.
- PROP (in_ready=0, out_valid=0, busy=1):
  - Each cycle compute s = limb[k] + carry, where s is LIMB_W+CARRY_W+1 bits wide.
  - Write dout bits [k*LIMB_W +: LIMB_W] = s[LIMB_W-1:0].
  - carry <= s >> LIMB_W; carry register is CARRY_W+1 bits and never overflows.
  - When k==NUM_LIMBS-1: write the top CARRY_W+1 bits of dout = s >> LIMB_W, go to DONE. Otherwise k++.
- DONE:
  - out_valid=1; dout is held stable.
  - On out_ready=1 at an edge: out_valid<=0, go to IDLE.
  - in_ready stays 0 in DONE; there is no same-cycle accept.
- Latency and throughput:
  - An input accepted at edge t raises out_valid after edge t+NUM_LIMBS.
  - Throughput is at most 1 result per NUM_LIMBS+2 cycles.
- Handshake rules:
  - in_valid is ignored when in_ready=0.
  - din changes while busy do not affect the result.
  - out_valid, once high, stays high with dout unchanged until out_ready is seen.
- Arithmetic: exact integer, no modular reduction, no truncation. The output width bounds the worst case (all limbs 2^(LIMB_W+CARRY_W)-1).
- Reset mid-operation (PROP or DONE): the in-flight result is discarded, all outputs return to reset values immediately, and no partial output is flagged valid.
- out_ready asserted while out_valid=0 has no effect.

Test Plan:
- All limbs 0, out_ready=1 → out_valid after 4 cycles, dout=0, back to IDLE the next cycle with in_ready=1.
- din[0]=2^67-1, other limbs 0 → dout=2^67-1: bits[63:0] all ones, bits[66:64]=7, all higher bits 0.
- All four limbs = 2^64 → dout = 2^64+2^128+2^192+2^256; checks the carry out of the top limb into bit 256.
- All limbs = 2^67-1 → dout = (2^67-1)*(1+2^64+2^128+2^192); no overflow, and the full value matches the bench's bignum model.
- Backpressure:
  - Hold out_ready=0 for 10 cycles in DONE → out_valid stays 1 and dout stays stable.
  - in_valid pulses during PROP/DONE are ignored (in_ready=0).
  - Releasing out_ready completes the handshake once.
- Assert rstn=1 at k=2 of PROP → outputs immediately return to reset values.
- After deassertion, a new input (limb0=5) → dout=5 with latency 4.

Source files
------------

// File: rtl/redundant_carry_norm_if.sv
// Handshake bundle between the constant-multiplier output and the carry normaliser.
// The master drives redundant operands in and takes results out; the slave is the normaliser.
interface redundant_carry_norm_if #(
  parameter int NUM_LIMBS = 4,
  parameter int LIMB_W    = 64,
  parameter int CARRY_W   = 3
) ();
  localparam int DIN_W  = NUM_LIMBS * (LIMB_W + CARRY_W);
  localparam int DOUT_W = NUM_LIMBS * LIMB_W + CARRY_W + 1;

  logic              in_valid;
  logic              in_ready;
  logic [DIN_W-1:0]  din;
  logic              out_valid;
  logic              out_ready;
  logic [DOUT_W-1:0] dout;
  logic              busy;

  modport master (
    output in_valid, din, out_ready,
    input  in_ready, out_valid, dout, busy
  );

  modport slave (
    input  in_valid, din, out_ready,
    output in_ready, out_valid, dout, busy
  );
endinterface

// File: rtl/redundant_carry_norm.sv
// Serial carry normaliser: folds one redundant limb per cycle into an exact
// non-redundant integer and holds it under a valid/ready handshake.
module redundant_carry_norm #(
  parameter int NUM_LIMBS = 4,
  parameter int LIMB_W    = 64,
  parameter int CARRY_W   = 3
) (
  input  logic                  clk,
  input  logic                  rstn,
  redundant_carry_norm_if.slave bus
);
  localparam int IN_W   = LIMB_W + CARRY_W;
  localparam int S_W    = IN_W + 1;
  localparam int C_W    = CARRY_W + 1;
  localparam int DOUT_W = NUM_LIMBS * LIMB_W + CARRY_W + 1;
  localparam int K_W    = (NUM_LIMBS > 1) ? $clog2(NUM_LIMBS) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PROP = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [IN_W-1:0]   limb_q [NUM_LIMBS];
  logic [IN_W-1:0]   limb_d [NUM_LIMBS];
  logic [K_W-1:0]    k_q, k_d;
  logic [C_W-1:0]    carry_q, carry_d;
  logic [DOUT_W-1:0] dout_q, dout_d;
  logic              in_ready_q, out_valid_q, busy_q;
  logic [S_W-1:0]    sum;

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.dout      = dout_q;
  assign bus.busy      = busy_q;

  // Next-state and datapath: one limb plus the running carry per PROP cycle
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    carry_d = carry_q;
    dout_d  = dout_q;
    limb_d  = limb_q;
    sum     = {1'b0, limb_q[k_q]} + {{(S_W-C_W){1'b0}}, carry_q};

    case (state_q)
      IDLE: begin
        if (bus.in_valid && in_ready_q) begin
          for (int i = 0; i < NUM_LIMBS; i++) begin
            limb_d[i] = bus.din[i*IN_W +: IN_W];
          end
          carry_d = '0;
          k_d     = '0;
          state_d = PROP;
        end else begin
          state_d = IDLE;
        end
      end
      PROP: begin
        dout_d[int'(k_q)*LIMB_W +: LIMB_W] = sum[LIMB_W-1:0];
        carry_d = sum[S_W-1:LIMB_W];
        // The last limb's carry-out becomes the top bits of the result
        if (k_q == K_W'(NUM_LIMBS - 1)) begin
          dout_d[DOUT_W-1 -: C_W] = sum[S_W-1:LIMB_W];
          state_d = DONE;
        end else begin
          k_d = k_q + K_W'(1);
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, datapath and handshake registers; flags are decoded from the next state
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      state_q     <= IDLE;
      k_q         <= '0;
      carry_q     <= '0;
      dout_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      for (int i = 0; i < NUM_LIMBS; i++) begin
        limb_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      carry_q     <= carry_d;
      dout_q      <= dout_d;
      in_ready_q  <= (state_d == IDLE);
      out_valid_q <= (state_d == DONE);
      busy_q      <= (state_d != IDLE);
      for (int i = 0; i < NUM_LIMBS; i++) begin
        limb_q[i] <= limb_d[i];
      end
    end
  end
endmodule

// File: tb/tb_redundant_carry_norm.sv
// Scoreboard bench for redundant_carry_norm: expected integers come from a
// shift-and-add model of the input limbs and are popped when results appear.
module tb_redundant_carry_norm;
  localparam int NUM_LIMBS = 4;
  localparam int LIMB_W    = 64;
  localparam int CARRY_W   = 3;
  localparam int IN_W      = LIMB_W + CARRY_W;
  localparam int DIN_W     = NUM_LIMBS * IN_W;
  localparam int DOUT_W    = NUM_LIMBS * LIMB_W + CARRY_W + 1;

  logic clk;
  logic rstn;
  int   tests_run;
  int   tests_failed;
  logic [DOUT_W-1:0] exp_q [$];

  redundant_carry_norm_if #(.NUM_LIMBS(NUM_LIMBS), .LIMB_W(LIMB_W), .CARRY_W(CARRY_W)) bus ();

  redundant_carry_norm #(.NUM_LIMBS(NUM_LIMBS), .LIMB_W(LIMB_W), .CARRY_W(CARRY_W)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DIN_W-1:0] pack4(input logic [IN_W-1:0] l0, input logic [IN_W-1:0] l1,
                                             input logic [IN_W-1:0] l2, input logic [IN_W-1:0] l3);
    return {l3, l2, l1, l0};
  endfunction

  function automatic logic [DOUT_W-1:0] model(input logic [DIN_W-1:0] d);
    logic [DOUT_W-1:0] acc;
    logic [IN_W-1:0]   l;
    acc = '0;
    for (int i = 0; i < NUM_LIMBS; i++) begin
      l   = d[i*IN_W +: IN_W];
      acc = acc + (DOUT_W'(l) << (i * LIMB_W));
    end
    return acc;
  endfunction

  function automatic logic [DOUT_W-1:0] pop_exp();
    if (exp_q.size() > 0) return exp_q.pop_front();
    return 'x;
  endfunction

  function automatic logic [IN_W-1:0] rand_limb();
    logic [95:0] r;
    r = {$urandom(), $urandom(), $urandom()};
    return r[IN_W-1:0];
  endfunction

  // Present one operand once in_ready is seen; returns at the negedge after the accepting edge
  task automatic send(input logic [DIN_W-1:0] v, input bit hold);
    int g;
    g = 0;
    while (!bus.in_ready && g < 50) begin
      @(negedge clk);
      g++;
    end
    bus.din      = v;
    bus.in_valid = 1'b1;
    exp_q.push_back(model(v));
    @(negedge clk);
    if (!hold) bus.in_valid = 1'b0;
  endtask

  task automatic collect(output logic [DOUT_W-1:0] d, output int cyc);
    cyc = 0;
    while (!bus.out_valid && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    d = bus.dout;
  endtask

  task automatic test_reset();
    rstn          = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.din       = '0;
    repeat (3) @(negedge clk);
    tests_run++;
    if (bus.in_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_in_ready got=%b want=1", bus.in_ready); end
    tests_run++;
    if (bus.out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid got=%b want=0", bus.out_valid); end
    tests_run++;
    if (bus.busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy got=%b want=0", bus.busy); end
    tests_run++;
    if (bus.dout !== '0) begin tests_failed++; $display("FAIL reset_dout got=%h want=0", bus.dout); end
    rstn = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_zero();
    logic [DOUT_W-1:0] d;
    int cyc;
    bus.out_ready = 1'b1;
    send('0, 1'b0);
    collect(d, cyc);
    tests_run++;
    if (cyc !== 4) begin tests_failed++; $display("FAIL zero_latency got=%0d want=4", cyc); end
    tests_run++;
    if (d !== pop_exp()) begin tests_failed++; $display("FAIL zero_dout got=%h want=0", d); end
    @(negedge clk);
    tests_run++;
    if ({bus.out_valid, bus.in_ready} !== 2'b01) begin
      tests_failed++; $display("FAIL zero_return_idle got valid=%b ready=%b want valid=0 ready=1", bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic test_single_limb();
    logic [DOUT_W-1:0] d;
    logic [DOUT_W-1:0] e;
    int cyc;
    bus.out_ready = 1'b1;
    send(pack4('1, '0, '0, '0), 1'b0);
    collect(d, cyc);
    e = pop_exp();
    tests_run++;
    if (cyc !== 4) begin tests_failed++; $display("FAIL single_latency got=%0d want=4", cyc); end
    tests_run++;
    if (d !== e) begin tests_failed++; $display("FAIL single_dout got=%h want=%h", d, e); end
    tests_run++;
    if (d[63:0] !== 64'hFFFF_FFFF_FFFF_FFFF || d[66:64] !== 3'd7 || d[DOUT_W-1:67] !== '0) begin
      tests_failed++; $display("FAIL single_fields got=%h want low 67 bits set only", d);
    end
    @(negedge clk);
  endtask

  task automatic test_carry_top();
    logic [DOUT_W-1:0] d;
    logic [DOUT_W-1:0] e;
    logic [IN_W-1:0]   p;
    int cyc;
    p = '0;
    p[64] = 1'b1;
    e = '0;
    e[64] = 1'b1; e[128] = 1'b1; e[192] = 1'b1; e[256] = 1'b1;
    bus.out_ready = 1'b1;
    send(pack4(p, p, p, p), 1'b0);
    collect(d, cyc);
    tests_run++;
    if (d !== e) begin tests_failed++; $display("FAIL carry_top_const got=%h want=%h", d, e); end
    e = pop_exp();
    tests_run++;
    if (d !== e) begin tests_failed++; $display("FAIL carry_top_model got=%h want=%h", d, e); end
    @(negedge clk);
  endtask

  task automatic test_all_max();
    logic [DOUT_W-1:0] d;
    logic [DOUT_W-1:0] e;
    logic [DOUT_W-1:0] mult;
    logic [DOUT_W-1:0] m;
    int cyc;
    mult = '0;
    mult[0] = 1'b1; mult[64] = 1'b1; mult[128] = 1'b1; mult[192] = 1'b1;
    m = '0;
    m[IN_W-1:0] = '1;
    bus.out_ready = 1'b1;
    send(pack4('1, '1, '1, '1), 1'b0);
    collect(d, cyc);
    e = pop_exp();
    tests_run++;
    if (d !== e) begin tests_failed++; $display("FAIL all_max_model got=%h want=%h", d, e); end
    e = m * mult;
    tests_run++;
    if (d !== e) begin tests_failed++; $display("FAIL all_max_product got=%h want=%h", d, e); end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    logic [DOUT_W-1:0] d;
    logic [DOUT_W-1:0] e;
    logic [DIN_W-1:0]  v;
    int cyc;
    v = pack4(67'd123, 67'd456, rand_limb(), rand_limb());
    bus.out_ready = 1'b0;
    send(v, 1'b1);
    bus.din = ~v;
    collect(d, cyc);
    e = pop_exp();
    tests_run++;
    if (cyc !== 4) begin tests_failed++; $display("FAIL bp_latency got=%0d want=4", cyc); end
    tests_run++;
    if (d !== e) begin tests_failed++; $display("FAIL bp_dout got=%h want=%h", d, e); end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      bus.din      = pack4(rand_limb(), rand_limb(), rand_limb(), rand_limb());
      bus.in_valid = 1'b1;
      tests_run++;
      if ({bus.out_valid, bus.in_ready, bus.busy} !== 3'b101 || bus.dout !== d) begin
        tests_failed++;
        $display("FAIL bp_hold cycle=%0d got valid=%b ready=%b busy=%b dout=%h want valid=1 ready=0 busy=1 dout=%h",
                 i, bus.out_valid, bus.in_ready, bus.busy, bus.dout, d);
      end
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    tests_run++;
    if ({bus.out_valid, bus.in_ready} !== 2'b01) begin
      tests_failed++; $display("FAIL bp_release got valid=%b ready=%b want valid=0 ready=1", bus.out_valid, bus.in_ready);
    end
    repeat (3) @(negedge clk);
    tests_run++;
    if ({bus.out_valid, bus.busy} !== 2'b00) begin
      tests_failed++; $display("FAIL bp_once got valid=%b busy=%b want 0 0", bus.out_valid, bus.busy);
    end
  endtask

  task automatic test_reset_mid();
    bus.out_ready = 1'b1;
    send(pack4(rand_limb(), rand_limb(), rand_limb(), rand_limb()), 1'b0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    #1;
    void'(exp_q.pop_back());
    tests_run++;
    if ({bus.in_ready, bus.out_valid, bus.busy} !== 3'b100 || bus.dout !== '0) begin
      tests_failed++;
      $display("FAIL reset_mid got ready=%b valid=%b busy=%b dout=%h want 1 0 0 0",
               bus.in_ready, bus.out_valid, bus.busy, bus.dout);
    end
    @(negedge clk);
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    tests_run++;
    if ({bus.out_valid, bus.busy, bus.in_ready} !== 3'b001) begin
      tests_failed++; $display("FAIL reset_mid_after got valid=%b busy=%b ready=%b want 0 0 1", bus.out_valid, bus.busy, bus.in_ready);
    end
  endtask

  task automatic test_after_reset();
    logic [DOUT_W-1:0] d;
    logic [DOUT_W-1:0] e;
    int cyc;
    bus.out_ready = 1'b1;
    send(pack4(67'd5, '0, '0, '0), 1'b0);
    collect(d, cyc);
    e = pop_exp();
    tests_run++;
    if (cyc !== 4) begin tests_failed++; $display("FAIL after_reset_latency got=%0d want=4", cyc); end
    tests_run++;
    if (d !== e || d !== DOUT_W'(5)) begin tests_failed++; $display("FAIL after_reset_dout got=%h want=5", d); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [DOUT_W-1:0] d;
    logic [DOUT_W-1:0] e;
    int cyc;
    bus.out_ready = 1'b1;
    for (int n = 0; n < 4; n++) begin
      send(pack4(rand_limb(), rand_limb(), rand_limb(), rand_limb()), 1'b0);
      collect(d, cyc);
      e = pop_exp();
      tests_run++;
      if (cyc !== 4 || d !== e) begin
        tests_failed++; $display("FAIL b2b_%0d got lat=%0d dout=%h want lat=4 dout=%h", n, cyc, d, e);
      end
      @(negedge clk);
    end
    tests_run++;
    if (exp_q.size() !== 0) begin tests_failed++; $display("FAIL scoreboard_empty got=%0d want=0", exp_q.size()); end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    test_reset();
    test_zero();
    test_single_limb();
    test_carry_top();
    test_all_max();
    test_backpressure();
    test_reset_mid();
    test_after_reset();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
